// File: rtl/dma_burst_read_model_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_model_pkg
// Brief    : Shared state encoding and data-pattern helpers for the burst-read
//            DMA model.
// Revision : 1.0 - initial release
// ============================================================================
package dma_model_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LAT  = 2'd1,
        BEAT = 2'd2,
        GAP  = 2'd3
    } dma_state_t;

    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    // Lane word = {addr[addr_lsb +: 16-bw-lw], beat[bw-1:0], lane[lw-1:0]}, truncated to 16 bits
    function automatic logic [15:0] pattern_lane(
        input logic [63:0] addr,
        input int          beat,
        input int          lane,
        input int          addr_lsb,
        input int          bw,
        input int          lw
    );
        logic [63:0] v_word;
        v_word = ((addr >> addr_lsb) << (bw + lw))
               | (64'(beat) << lw)
               | 64'(lane & ((1 << lw) - 1));
        return v_word[15:0];
    endfunction

endpackage : dma_model_pkg
`default_nettype wire

// File: rtl/dma_burst_read_model_if.sv
`default_nettype none
// ============================================================================
// Module   : dma_burst_read_model_if
// Brief    : Request/response bundle between DMA requesters and the engine.
// Revision : 1.0 - initial release
// ============================================================================
interface dma_burst_read_model_if #(
    parameter int CHANNELS = 2,
    parameter int ADDR_W   = 30,
    parameter int DATA_W   = 32
);
    logic [CHANNELS-1:0]        DMA_START;
    logic [CHANNELS*ADDR_W-1:0] DMA_RD_ADDR;
    logic [CHANNELS-1:0]        DMA_READY;
    logic [DATA_W-1:0]          DMA_RD_DATA;
    logic [CHANNELS-1:0]        DMA_RD_DATA_VALID;
    logic                       DMA_RD_LAST;
    logic                       DMA_BUSY;

    modport master (
        output DMA_START, DMA_RD_ADDR,
        input  DMA_READY, DMA_RD_DATA, DMA_RD_DATA_VALID, DMA_RD_LAST, DMA_BUSY
    );

    modport slave (
        input  DMA_START, DMA_RD_ADDR,
        output DMA_READY, DMA_RD_DATA, DMA_RD_DATA_VALID, DMA_RD_LAST, DMA_BUSY
    );
endinterface : dma_burst_read_model_if
`default_nettype wire

// File: rtl/dma_burst_read_model_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter: first pending channel at or
//            after the pointer wins; next pointer is winner+1 mod CHANNELS.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import dma_model_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int PTR_W    = clog2_min1(CHANNELS)
) (
    input  logic [CHANNELS-1:0] i_pending,
    input  logic [PTR_W-1:0]    i_ptr,
    output logic [CHANNELS-1:0] o_grant,
    output logic [PTR_W-1:0]    o_next_ptr,
    output logic                o_any
);

    logic [CHANNELS-1:0] w_rot;
    int                  w_off;
    int                  w_sel;

    always_comb begin
        // Rotate so bit 0 is the channel at the pointer; lowest set bit wins
        w_rot = CHANNELS'({i_pending, i_pending} >> i_ptr);
        w_off = 0;
        o_any = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = i;
                o_any = 1'b1;
            end
        end
        w_sel = int'(i_ptr) + w_off;
        if (w_sel >= CHANNELS) begin
            w_sel = w_sel - CHANNELS;
        end
        o_grant    = o_any ? (CHANNELS'(1) << w_sel) : '0;
        o_next_ptr = (w_sel + 1 >= CHANNELS) ? '0 : PTR_W'(w_sel + 1);
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/dma_burst_read_model.sv
`default_nettype none
// ============================================================================
// Module   : dma_burst_read_model
// Brief    : Multi-channel burst-read DMA model returning address-encoded
//            pattern data, channels served round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module dma_burst_read_model
    import dma_model_pkg::*;
#(
    parameter int CHANNELS      = 2,
    parameter int ADDR_W        = 30,
    parameter int DATA_W        = 32,
    parameter int BURST_LEN     = 8,
    parameter int START_LATENCY = 0,
    parameter int BEAT_GAP      = 1,
    parameter int ADDR_LSB      = 3
) (
    input  logic                   CLK,
    input  logic                   RESET,
    dma_burst_read_model_if.slave  bus
);

    localparam int c_LANES   = DATA_W / 16;
    localparam int c_BW      = $clog2(BURST_LEN);
    localparam int c_LW      = clog2_min1(c_LANES);
    localparam int c_PTR_W   = clog2_min1(CHANNELS);
    localparam int c_CNT_MAX = (START_LATENCY > BEAT_GAP) ? START_LATENCY : BEAT_GAP;
    localparam int c_CNT_W   = clog2_min1(c_CNT_MAX + 1);

    localparam dma_state_t         c_FIRST_STATE = (START_LATENCY > 0) ? LAT : BEAT;
    localparam logic [c_CNT_W-1:0] c_LAT_LOAD    = c_CNT_W'((START_LATENCY > 0) ? START_LATENCY - 1 : 0);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD    = c_CNT_W'((BEAT_GAP > 0) ? BEAT_GAP - 1 : 0);

    dma_state_t          r_state;
    dma_state_t          w_state_nxt;
    logic [CHANNELS-1:0] r_pending;
    logic [CHANNELS-1:0] r_owner;
    logic [ADDR_W-1:0]   r_addr [CHANNELS];
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [c_PTR_W-1:0]  r_ptr;
    logic [c_BW-1:0]     r_beat;
    logic [c_BW-1:0]     w_beat_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;

    logic [CHANNELS-1:0] w_ready;
    logic [CHANNELS-1:0] w_capture;
    logic [CHANNELS-1:0] w_grant;
    logic [c_PTR_W-1:0]  w_next_ptr;
    logic                w_any;
    logic                w_last_beat;
    logic                w_take;
    logic [ADDR_W-1:0]   w_grant_addr;
    logic [DATA_W-1:0]   w_data;

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arb (
        .i_pending  (r_pending),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_next_ptr (w_next_ptr),
        .o_any      (w_any)
    );

    // A channel stays busy from capture until its final beat has gone out
    assign w_ready     = ~(r_pending | r_owner);
    assign w_capture   = bus.DMA_START & w_ready;
    assign w_last_beat = (r_state == BEAT) && (&r_beat);
    assign w_take      = w_any && ((r_state == IDLE) || w_last_beat);

    always_comb begin
        w_grant_addr = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_grant[c]) begin
                w_grant_addr = w_grant_addr | r_addr[c];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_beat_nxt  = r_beat;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = c_FIRST_STATE;
                    w_cnt_nxt   = c_LAT_LOAD;
                    w_beat_nxt  = '0;
                end
            end
            LAT, GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = BEAT;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            BEAT: begin
                if (w_last_beat) begin
                    if (w_any) begin
                        w_state_nxt = c_FIRST_STATE;
                        w_cnt_nxt   = c_LAT_LOAD;
                        w_beat_nxt  = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_beat_nxt = r_beat + c_BW'(1);
                    if (BEAT_GAP > 0) begin
                        w_state_nxt = GAP;
                        w_cnt_nxt   = c_GAP_LOAD;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_pending  <= '0;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_beat     <= '0;
            r_cnt      <= '0;
            r_cur_addr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_beat    <= w_beat_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= (r_pending & ~(w_take ? w_grant : '0)) | w_capture;
            if (w_take) begin
                r_owner    <= w_grant;
                r_ptr      <= w_next_ptr;
                r_cur_addr <= w_grant_addr;
            end else if (w_last_beat) begin
                r_owner <= '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_addr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_capture[c]) begin
                    r_addr[c] <= bus.DMA_RD_ADDR[c*ADDR_W +: ADDR_W];
                end
            end
        end
    end

    for (genvar k = 0; k < c_LANES; k++) begin : g_lane
        assign w_data[k*16 +: 16] = pattern_lane(64'(r_cur_addr), int'(r_beat), k,
                                                 ADDR_LSB, c_BW, c_LW);
    end

    assign bus.DMA_READY         = w_ready;
    assign bus.DMA_RD_DATA_VALID = (r_state == BEAT) ? r_owner : '0;
    assign bus.DMA_RD_DATA       = (r_state == BEAT) ? w_data : '0;
    assign bus.DMA_RD_LAST       = w_last_beat;
    assign bus.DMA_BUSY          = (r_state != IDLE);

endmodule : dma_burst_read_model
`default_nettype wire

// File: tb/tb_dma_burst_read_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_burst_read_model
// Brief    : Self-checking bench for two DMA model configurations against a
//            transaction-level reference (RR order, beat count, data pattern).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_burst_read_model;

    logic CLK;
    logic rst_a;
    logic rst_b;

    int n_chk;
    int n_err;
    int sel;
    int rr_ptr [2];

    logic [29:0] req_addr [8];
    logic [7:0]  obs_valid;
    logic [7:0]  obs_ready;
    logic [63:0] obs_data;
    logic        obs_last;
    logic        obs_busy;

    dma_burst_read_model_if #(.CHANNELS(2), .ADDR_W(30), .DATA_W(32)) bus_a ();
    dma_burst_read_model_if #(.CHANNELS(3), .ADDR_W(30), .DATA_W(64)) bus_b ();

    dma_burst_read_model #(
        .CHANNELS(2), .ADDR_W(30), .DATA_W(32), .BURST_LEN(8),
        .START_LATENCY(0), .BEAT_GAP(1), .ADDR_LSB(3)
    ) dut_a (
        .CLK   (CLK),
        .RESET (rst_a),
        .bus   (bus_a)
    );

    dma_burst_read_model #(
        .CHANNELS(3), .ADDR_W(30), .DATA_W(64), .BURST_LEN(4),
        .START_LATENCY(3), .BEAT_GAP(0), .ADDR_LSB(3)
    ) dut_b (
        .CLK   (CLK),
        .RESET (rst_b),
        .bus   (bus_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no summary, expected completion");
        $fatal(1);
    end

    always_comb begin
        if (sel == 0) begin
            obs_valid = 8'(bus_a.DMA_RD_DATA_VALID);
            obs_ready = 8'(bus_a.DMA_READY);
            obs_data  = 64'(bus_a.DMA_RD_DATA);
            obs_last  = bus_a.DMA_RD_LAST;
            obs_busy  = bus_a.DMA_BUSY;
        end else begin
            obs_valid = 8'(bus_b.DMA_RD_DATA_VALID);
            obs_ready = 8'(bus_b.DMA_READY);
            obs_data  = bus_b.DMA_RD_DATA;
            obs_last  = bus_b.DMA_RD_LAST;
            obs_busy  = bus_b.DMA_BUSY;
        end
    end

    // Configuration of each instance as seen by the reference model
    function automatic int cfg_ch(input int d);  return (d == 0) ? 2 : 3;   endfunction
    function automatic int cfg_bl(input int d);  return (d == 0) ? 8 : 4;   endfunction
    function automatic int cfg_lat(input int d); return (d == 0) ? 0 : 3;   endfunction
    function automatic int cfg_gap(input int d); return (d == 0) ? 1 : 0;   endfunction
    function automatic int cfg_dw(input int d);  return (d == 0) ? 32 : 64; endfunction
    function automatic logic [7:0] all_mask(input int d);
        return 8'((1 << cfg_ch(d)) - 1);
    endfunction

    function automatic logic [15:0] exp_lane(input logic [63:0] addr, input int beat,
                                             input int lane, input int d);
        int          bw;
        int          lw;
        logic [63:0] v;
        bw = $clog2(cfg_bl(d));
        lw = (cfg_dw(d) / 16 > 1) ? $clog2(cfg_dw(d) / 16) : 1;
        v  = (addr / 64'd8) * (64'd1 << (bw + lw)) + 64'(beat) * (64'd1 << lw) + 64'(lane);
        return v[15:0];
    endfunction

    task automatic set_sel(input int d);
        sel = d;
        #1;
    endtask

    task automatic drive_start(input int d, input logic [7:0] mask);
        if (d == 0) begin
            bus_a.DMA_START = mask[1:0];
            for (int c = 0; c < 2; c++) bus_a.DMA_RD_ADDR[c*30 +: 30] = req_addr[c];
        end else begin
            bus_b.DMA_START = mask[2:0];
            for (int c = 0; c < 3; c++) bus_b.DMA_RD_ADDR[c*30 +: 30] = req_addr[c];
        end
    endtask

    // Waits (bounded) for the first beat, then checks every beat and gap cycle
    task automatic check_burst(input int d, input int ch, input logic [29:0] addr,
                               output int wait_cycles);
        logic [63:0] exp;
        int          w;
        w = 0;
        while (obs_valid == 8'h00 && w < 64) begin
            @(negedge CLK);
            w++;
        end
        wait_cycles = w;
        if (obs_valid == 8'h00) begin
            n_chk++;
            n_err++;
            $display("FAIL burst_timeout: ch%0d got no VALID in %0d cycles, expected a burst", ch, w);
            return;
        end
        for (int b = 0; b < cfg_bl(d); b++) begin
            exp = '0;
            for (int k = 0; k < cfg_dw(d) / 16; k++) exp[k*16 +: 16] = exp_lane(64'(addr), b, k, d);
            n_chk++;
            if (obs_valid !== (8'd1 << ch) || obs_data !== exp ||
                obs_last !== (b == cfg_bl(d) - 1) || obs_busy !== 1'b1) begin
                n_err++;
                $display("FAIL beat d%0d ch%0d b%0d: got valid=%h data=%h last=%b busy=%b, expected valid=%h data=%h last=%b busy=1",
                         d, ch, b, obs_valid, obs_data, obs_last, obs_busy,
                         8'd1 << ch, exp, (b == cfg_bl(d) - 1));
            end
            if (b != cfg_bl(d) - 1) begin
                for (int g = 0; g < cfg_gap(d); g++) begin
                    @(negedge CLK);
                    n_chk++;
                    if (obs_valid !== 8'h00 || obs_data !== 64'h0 || obs_last !== 1'b0 || obs_busy !== 1'b1) begin
                        n_err++;
                        $display("FAIL gap d%0d ch%0d b%0d: got valid=%h data=%h last=%b busy=%b, expected 00/0/0/1",
                                 d, ch, b, obs_valid, obs_data, obs_last, obs_busy);
                    end
                end
                @(negedge CLK);
            end
        end
    endtask

    // Pulses START on the mask, then expects bursts in RR order, back to back
    task automatic run_multi(input int d, input logic [7:0] mask);
        int order [$];
        int w;
        int exp_w;
        int ch;
        for (int i = 0; i < cfg_ch(d); i++) begin
            ch = (rr_ptr[d] + i) % cfg_ch(d);
            if (mask[ch]) order.push_back(ch);
        end
        @(negedge CLK);
        drive_start(d, mask);
        @(negedge CLK);
        drive_start(d, 8'h00);
        n_chk++;
        if ((obs_ready & mask) !== 8'h00) begin
            n_err++;
            $display("FAIL ready_drop d%0d: got ready=%h, expected bits %h low", d, obs_ready, mask);
        end
        foreach (order[i]) begin
            check_burst(d, order[i], req_addr[order[i]], w);
            exp_w = (i == 0) ? 1 + cfg_lat(d) : cfg_lat(d);
            n_chk++;
            if (w !== exp_w) begin
                n_err++;
                $display("FAIL first_beat_latency d%0d ch%0d: got %0d, expected %0d", d, order[i], w, exp_w);
            end
            rr_ptr[d] = (order[i] + 1) % cfg_ch(d);
            @(negedge CLK);
            n_chk++;
            if (obs_ready[order[i]] !== 1'b1) begin
                n_err++;
                $display("FAIL ready_return d%0d ch%0d: got %b, expected 1", d, order[i], obs_ready[order[i]]);
            end
        end
        n_chk++;
        if (obs_busy !== 1'b0 || obs_ready !== all_mask(d) || obs_valid !== 8'h00) begin
            n_err++;
            $display("FAIL idle_after d%0d: got busy=%b ready=%h valid=%h, expected 0/%h/00",
                     d, obs_busy, obs_ready, obs_valid, all_mask(d));
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            set_sel(d);
            n_chk++;
            if (obs_ready !== all_mask(d)) begin
                n_err++;
                $display("FAIL reset_ready d%0d: got %h, expected %h", d, obs_ready, all_mask(d));
            end
            n_chk++;
            if (obs_valid !== 8'h00 || obs_last !== 1'b0) begin
                n_err++;
                $display("FAIL reset_valid d%0d: got valid=%h last=%b, expected 00/0", d, obs_valid, obs_last);
            end
            n_chk++;
            if (obs_data !== 64'h0 || obs_busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_data d%0d: got data=%h busy=%b, expected 0/0", d, obs_data, obs_busy);
            end
        end
        @(negedge CLK);
        rst_a = 1'b0;
        rst_b = 1'b0;
        rr_ptr[0] = 0;
        rr_ptr[1] = 0;
    endtask

    task automatic test_back_to_back();
        set_sel(0);
        req_addr[0] = 30'h08;
        req_addr[1] = 30'h10;
        run_multi(0, 8'h03);
    endtask

    task automatic test_single_burst();
        set_sel(0);
        req_addr[0] = 30'h1000_0000;
        run_multi(0, 8'h01);
    endtask

    task automatic test_ignored_start();
        logic [29:0] keep;
        int          w;
        int          stray;
        set_sel(0);
        keep        = 30'($urandom);
        req_addr[0] = keep;
        @(negedge CLK);
        drive_start(0, 8'h01);
        @(negedge CLK);
        req_addr[0] = keep ^ 30'h0000_0F38;
        drive_start(0, 8'h01);
        n_chk++;
        if (obs_ready[0] !== 1'b0) begin
            n_err++;
            $display("FAIL ignored_ready: got ready0=%b, expected 0", obs_ready[0]);
        end
        @(negedge CLK);
        drive_start(0, 8'h00);
        check_burst(0, 0, keep, w);
        n_chk++;
        if (w !== 0) begin
            n_err++;
            $display("FAIL ignored_latency: got %0d, expected 0", w);
        end
        rr_ptr[0] = 1;
        stray = 0;
        repeat (24) begin
            @(negedge CLK);
            if (obs_valid !== 8'h00) stray++;
        end
        n_chk++;
        if (stray !== 0 || obs_ready !== 8'h03) begin
            n_err++;
            $display("FAIL ignored_extra: got %0d stray beats ready=%h, expected 0 and 03", stray, obs_ready);
        end
    endtask

    task automatic test_reset_mid_burst();
        int first;
        int w;
        int stray;
        set_sel(0);
        req_addr[0] = 30'($urandom);
        req_addr[1] = 30'($urandom);
        first = rr_ptr[0];
        @(negedge CLK);
        drive_start(0, 8'h03);
        @(negedge CLK);
        drive_start(0, 8'h00);
        w = 0;
        while (obs_valid == 8'h00 && w < 64) begin
            @(negedge CLK);
            w++;
        end
        repeat (6) @(negedge CLK);
        n_chk++;
        if (obs_valid !== (8'd1 << first) || obs_data[15:0] !== exp_lane(64'(req_addr[first]), 3, 0, 0)) begin
            n_err++;
            $display("FAIL mid_beat3: got valid=%h lane0=%h, expected %h/%h", obs_valid, obs_data[15:0],
                     8'd1 << first, exp_lane(64'(req_addr[first]), 3, 0, 0));
        end
        rst_a = 1'b1;
        @(negedge CLK);
        n_chk++;
        if (obs_valid !== 8'h00 || obs_ready !== 8'h03 || obs_busy !== 1'b0 || obs_data !== 64'h0) begin
            n_err++;
            $display("FAIL mid_reset: got valid=%h ready=%h busy=%b data=%h, expected 00/03/0/0",
                     obs_valid, obs_ready, obs_busy, obs_data);
        end
        @(negedge CLK);
        rst_a = 1'b0;
        rr_ptr[0] = 0;
        stray = 0;
        repeat (30) begin
            @(negedge CLK);
            if (obs_valid !== 8'h00) stray++;
        end
        n_chk++;
        if (stray !== 0) begin
            n_err++;
            $display("FAIL post_reset_beats: got %0d beats, expected 0", stray);
        end
    endtask

    task automatic test_latency_wide();
        set_sel(1);
        req_addr[0] = 30'h08;
        run_multi(1, 8'h01);
    endtask

    task automatic test_all_channels_b();
        set_sel(1);
        for (int c = 0; c < 3; c++) req_addr[c] = 30'($urandom);
        run_multi(1, 8'h07);
    endtask

    task automatic test_random();
        int          d;
        logic [7:0]  mask;
        for (int it = 0; it < 8; it++) begin
            d = it % 2;
            set_sel(d);
            for (int c = 0; c < 8; c++) req_addr[c] = 30'($urandom);
            mask = 8'($urandom_range(1, (1 << cfg_ch(d)) - 1));
            run_multi(d, mask);
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        sel   = 0;
        for (int c = 0; c < 8; c++) req_addr[c] = '0;
        bus_a.DMA_START   = '0;
        bus_a.DMA_RD_ADDR = '0;
        bus_b.DMA_START   = '0;
        bus_b.DMA_RD_ADDR = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;

        test_reset();
        test_back_to_back();
        test_single_burst();
        test_ignored_start();
        test_reset_mid_burst();
        test_latency_wide();
        test_all_channels_b();
        test_random();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_dma_burst_read_model
`default_nettype wire
